key_controller: RTL and testbench

Memory-mapped input device on the processor data bus; the read-side counterpart of the HEX display output controller. Synchronizes and debounces the four board push-buttons (KEY[3:0], active-low) and exposes the debounced state in a data register (KDATA). Exposes change status (ready, overrun) and an interrupt enable in a control register (KCTRL). Drives dbus only during reads of its own addresses and is high-Z otherwise.

---
 rtl/key_controller.sv | 124 ++++++++++++
 tb/tb_key_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_controller.sv
// key_controller: memory-mapped push-button input device.
// It synchronizes and debounces KEY[3:0] and presents the debounced level in KDATA.
// KCTRL holds the change status (ready, overrun) and the interrupt enable.
// The block drives dbus only while one of its own registers is being read.
module key_controller #(
    parameter int                 DBITS           = 32,
    parameter logic [DBITS-1:0]   DATA_ADDR       = 32'hF000_0010,
    parameter logic [DBITS-1:0]   CTRL_ADDR       = 32'hF000_0110,
    parameter int                 DEBOUNCE_CYCLES = 500000,
    parameter int                 CNT_BITS        = 20
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [DBITS-1:0] dbus,
    input  logic [DBITS-1:0] address,
    input  logic             wrtEn,
    input  logic [3:0]       KEY,
    output logic             intr
);

    // The counter value on which a still-differing key is accepted.
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_kdata;
    logic [CNT_BITS-1:0] r_cnt [4];
    logic                r_ready;
    logic                r_overrun;
    logic                r_ie;

    logic [3:0]          w_toggle;
    logic                w_chg;
    logic                w_rd_data;
    logic                w_rd_ctrl;
    logic                w_wr_ctrl;
    logic [DBITS-1:0]    w_kdata_word;
    logic [DBITS-1:0]    w_ctrl_word;

    // Bus decode. A read has side effects only at a clock edge.
    assign w_rd_data = (address == DATA_ADDR) && !wrtEn;
    assign w_rd_ctrl = (address == CTRL_ADDR) && !wrtEn;
    assign w_wr_ctrl = (address == CTRL_ADDR) &&  wrtEn;

    // Two-flop synchronizer on the inverted keys, so a 1 means "pressed".
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
        if (reset) begin
            r_sync1 <= 4'h0;
            r_sync2 <= 4'h0;
        end else begin
            r_sync1 <= ~KEY;
            r_sync2 <= r_sync1;
        end
    end

    // A key is accepted once it has differed from kdata for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        w_toggle = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_toggle[i] = (r_sync2[i] != r_kdata[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Any number of keys accepted on the same edge counts as a single change event.
    assign w_chg = |w_toggle;

    // Per-key debounce counters and the debounced state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kdata <= 4'h0;
            // NOTE: the counter array is only four small registers, so it is reset explicitly.
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_kdata[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_toggle[i]) begin
                    r_kdata[i] <= ~r_kdata[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Status and enable bits. When a new event and a clearing access land on the same edge, the new event wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_ie      <= 1'b0;
        end else begin
            if (w_chg) begin
                r_ready <= 1'b1;
            end else if (w_rd_data) begin
                r_ready <= 1'b0;
            end

            if (w_chg && r_ready && !w_rd_data) begin
                r_overrun <= 1'b1;
            end else if (w_wr_ctrl && !dbus[2]) begin
                r_overrun <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_ie <= dbus[8];
            end
        end
    end

    assign intr = r_ready & r_ie;

    assign w_kdata_word = {{(DBITS-4){1'b0}}, r_kdata};
    assign w_ctrl_word  = {{(DBITS-9){1'b0}}, r_ie, 5'b0, r_overrun, 1'b0, r_ready};

    // NOTE: the bus is shared, so every non-read cycle must release it to Z.
    assign dbus = w_rd_data ? w_kdata_word :
                  w_rd_ctrl ? w_ctrl_word  : {DBITS{1'bz}};

endmodule

// File: tb/tb_key_controller.sv
// Self-checking bench for key_controller, run with DEBOUNCE_CYCLES = 4.
// A table of per-cycle vectors covers the main sequence.
// Short hand-written sequences then cover reset, write and bus-release corner cases.
module tb_key_controller;

    localparam logic [31:0] DATA_ADDR = 32'hF000_0010;
    localparam logic [31:0] CTRL_ADDR = 32'hF000_0110;
    localparam logic [31:0] FREE_PAT  = 32'h1234_5670;

    localparam logic [1:0] OP_IDLE = 2'd0;
    localparam logic [1:0] OP_RDAT = 2'd1;
    localparam logic [1:0] OP_RCTL = 2'd2;
    localparam logic [1:0] OP_WCTL = 2'd3;

    typedef struct {
        logic [3:0]  key;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [3:0]  exp_kdata;
        logic [31:0] exp_ctrl;
        logic        exp_intr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        wrtEn;
    logic [3:0]  KEY;
    logic        intr;
    wire  [31:0] dbus;

    logic        tb_drive;
    logic [31:0] tb_data;

    int n_pass  = 0;
    int n_total = 0;

    vec_t vecs[$];

    assign dbus = tb_drive ? tb_data : 32'bz;

    key_controller #(
        .DBITS          (32),
        .DATA_ADDR      (DATA_ADDR),
        .CTRL_ADDR      (CTRL_ADDR),
        .DEBOUNCE_CYCLES(4),
        .CNT_BITS       (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .dbus   (dbus),
        .address(address),
        .wrtEn  (wrtEn),
        .KEY    (KEY),
        .intr   (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and stop 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A zero-edge read: the address is presented and released between edges, so no state changes.
    task automatic peek(input logic [31:0] addr, output logic [31:0] val);
        tb_drive = 1'b0;
        wrtEn    = 1'b0;
        address  = addr;
        #1;
        val      = dbus;
        address  = 32'h0;
    endtask

    // Check KDATA, KCTRL and intr against expectations without disturbing state.
    task automatic check_state(input string tag, input logic [3:0] kd, input logic [31:0] ctl, input logic irq);
        logic [31:0] v;
        peek(DATA_ADDR, v);
        check({tag, " kdata"}, v, {28'h0, kd});
        peek(CTRL_ADDR, v);
        check({tag, " kctrl"}, v, ctl);
        check({tag, " intr"}, {31'h0, intr}, {31'h0, irq});
    endtask

    // Present one bus operation. It takes effect at the next edge.
    task automatic bus_op(input logic [1:0] op, input logic [31:0] wdata);
        case (op)
            OP_RDAT: begin tb_drive = 1'b0; wrtEn = 1'b0; address = DATA_ADDR; end
            OP_RCTL: begin tb_drive = 1'b0; wrtEn = 1'b0; address = CTRL_ADDR; end
            OP_WCTL: begin tb_drive = 1'b1; tb_data = wdata; wrtEn = 1'b1; address = CTRL_ADDR; end
            default: begin tb_drive = 1'b0; wrtEn = 1'b0; address = 32'h0; end
        endcase
    endtask

    task automatic add(input int n, input logic [3:0] key, input logic [1:0] op, input logic [31:0] wdata,
                       input logic [3:0] kd, input logic [31:0] ctl, input logic irq);
        vec_t v;
        v.key = key; v.op = op; v.wdata = wdata;
        v.exp_kdata = kd; v.exp_ctrl = ctl; v.exp_intr = irq;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] v;

        // Per row, the expectations describe the state seen before that row's edge.
        // The row's KEY value and bus operation are then applied at that edge.
        // A key level sampled at edge n is accepted at edge n+5.
        // Press KEY0: accepted, then status read and KDATA read (clears ready).
        add(6, 4'hE, OP_IDLE, 0, 4'h0, 32'h000, 1'b0);  // rows 0-5
        add(1, 4'hE, OP_RCTL, 0, 4'h1, 32'h001, 1'b0);  // row 6
        add(1, 4'hE, OP_RDAT, 0, 4'h1, 32'h001, 1'b0);  // row 7
        // A 3-cycle glitch on KEY1 is rejected; a held press is accepted.
        add(3, 4'hC, OP_IDLE, 0, 4'h1, 32'h000, 1'b0);  // rows 8-10
        add(4, 4'hE, OP_IDLE, 0, 4'h1, 32'h000, 1'b0);  // rows 11-14
        add(6, 4'hC, OP_IDLE, 0, 4'h1, 32'h000, 1'b0);  // rows 15-20
        // A second unread change (KEY2) sets overrun; a write of 0 clears it.
        add(1, 4'h8, OP_IDLE, 0, 4'h3, 32'h001, 1'b0);  // row 21
        add(5, 4'h8, OP_IDLE, 0, 4'h3, 32'h001, 1'b0);  // rows 22-26
        add(1, 4'h8, OP_WCTL, 32'h0, 4'h7, 32'h005, 1'b0);  // row 27
        add(1, 4'h8, OP_RDAT, 0, 4'h7, 32'h001, 1'b0);  // row 28
        // Enable the interrupt, press KEY3: intr follows ready, and a KDATA read drops it.
        add(1, 4'h8, OP_WCTL, 32'h100, 4'h7, 32'h000, 1'b0);  // row 29
        add(6, 4'h0, OP_IDLE, 0, 4'h7, 32'h100, 1'b0);  // rows 30-35
        add(1, 4'h0, OP_RDAT, 0, 4'hF, 32'h101, 1'b1);  // row 36
        // Release KEY3, then KEY2 one edge later. KEY2 is accepted on the same edge as a KDATA read.
        add(1, 4'h8, OP_IDLE, 0, 4'hF, 32'h100, 1'b0);  // row 37
        add(5, 4'hC, OP_IDLE, 0, 4'hF, 32'h100, 1'b0);  // rows 38-42
        add(1, 4'hC, OP_RDAT, 0, 4'h7, 32'h101, 1'b1);  // row 43
        add(1, 4'hC, OP_IDLE, 0, 4'h3, 32'h101, 1'b1);  // row 44

        tb_drive = 1'b0;
        tb_data  = 32'h0;
        address  = 32'h0;
        wrtEn    = 1'b0;
        KEY      = 4'hF;
        reset    = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state. The bus must be released when the address is not one of ours.
        check_state("reset", 4'h0, 32'h0, 1'b0);
        tb_drive = 1'b1; tb_data = FREE_PAT; address = 32'h0; wrtEn = 1'b0;
        #1;
        check("reset bus released", dbus, FREE_PAT);
        tb_drive = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            check_state($sformatf("row%0d", i), vecs[i].exp_kdata, vecs[i].exp_ctrl, vecs[i].exp_intr);
            KEY = vecs[i].key;
            bus_op(vecs[i].op, vecs[i].wdata);
            step();
        end
        bus_op(OP_IDLE, 0);

        // Release keys so the counters run, then reset mid-count with KEY0 held.
        KEY = 4'hF;
        step();
        step();
        KEY   = 4'hE;
        reset = 1'b1;
        step();
        check_state("midreset", 4'h0, 32'h0, 1'b0);
        reset = 1'b0;
        // The held key needs the two synchronizer edges plus the debounce count after reset release.
        for (int i = 0; i < 5; i++) step();
        check_state("postreset wait", 4'h0, 32'h0, 1'b0);
        step();
        check_state("postreset accept", 4'h1, 32'h1, 1'b0);

        // Writes to KDATA are ignored. Writing 1 to ready or overrun has no effect.
        tb_drive = 1'b1; tb_data = 32'h0; wrtEn = 1'b1; address = DATA_ADDR;
        step();
        bus_op(OP_IDLE, 0);
        check_state("wr kdata ignored", 4'h1, 32'h1, 1'b0);
        bus_op(OP_WCTL, 32'h5);
        step();
        bus_op(OP_IDLE, 0);
        check_state("wr ones ignored", 4'h1, 32'h1, 1'b0);

        // An overrun set and an overrun clear on the same edge: the set wins.
        KEY = 4'hC;
        for (int i = 0; i < 5; i++) step();
        check_state("pre set-wins", 4'h1, 32'h1, 1'b0);
        bus_op(OP_WCTL, 32'h0);
        step();
        bus_op(OP_IDLE, 0);
        check_state("set wins", 4'h3, 32'h5, 1'b0);

        // Bus released again while kdata is nonzero.
        tb_drive = 1'b1; tb_data = FREE_PAT; address = 32'h0; wrtEn = 1'b0;
        #1;
        check("bus released", dbus, FREE_PAT);
        tb_drive = 1'b0;

        // A two-cycle KDATA read clears only ready. Overrun is untouched.
        bus_op(OP_RDAT, 0);
        #1;
        check("multi read data", dbus, 32'h3);
        step();
        step();
        bus_op(OP_IDLE, 0);
        peek(CTRL_ADDR, v);
        check("multi read ctrl", v, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
